mult_div_unit: RTL

- Parametrised, iterative multiply/divide unit with architectural HI/LO registers, replacing the combinational mult/mfhi/mflo path.
- Executes MULT, MULTU, DIV, DIVU over WIDTH cycles with a start/busy/done handshake; MTHI and MTLO write in one cycle.
- Sits beside the ALU, driven by the control unit's decoded MDU op; hi/lo feed the writeback mux for mfhi/mflo.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mdu_div_core.sv | 29 ++
 rtl/mult_div_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and two's-complement helpers.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    // Helpers work on a fixed wide word; callers zero-extend into it and
    // truncate the result back, which keeps the low bits exact for any
    // operand up to this width (the 2*WIDTH product included).
    localparam int MDU_MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdu_state_t;

    function automatic logic [MDU_MAX_W-1:0] mdu_neg(input logic [MDU_MAX_W-1:0] x);
        return -x;
    endfunction

    function automatic logic [MDU_MAX_W-1:0] mdu_mag(input logic [MDU_MAX_W-1:0] x,
                                                     input logic                 neg);
        return neg ? mdu_neg(x) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit and the multiply/divide
// unit. The master side issues operations, the slave side is the MDU.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );

endinterface

// File: rtl/mdu_div_core.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; a clear top bit of the difference means it fit
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use a radix-2 shift-add, DIV/DIVU a restoring divider; both run
// WIDTH iterations on magnitudes followed by a one-cycle sign-fix/commit.
// Build option: define MDU_DIV_EN to include the divider; without it
// DIV/DIVU complete as one-cycle no-ops and div_zero is tied low.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_t       state;
    mdu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd;
    logic             neg_res;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             op_mul;
    logic             op_div;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_iter;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef MDU_DIV_EN
    logic             is_div;
    logic             neg_rem;
    logic             dz;
    logic             div_zero_q;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .quo      (acc[WIDTH-1:0]),
        .divisor  (opnd),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Quotient sign is the XOR of operand signs; remainder follows the dividend
    always_comb begin
        quo_fix = WIDTH'(mdu_mag(MDU_MAX_W'(acc[WIDTH-1:0]), neg_res));
        rem_fix = WIDTH'(mdu_mag(MDU_MAX_W'(acc[2*WIDTH-1:WIDTH]), neg_rem));
    end

    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

    // Decode the request and take operand magnitudes for the signed ops
    always_comb begin
        op_mul    = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
        op_div    = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
        signed_op = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_mag     = WIDTH'(mdu_mag(MDU_MAX_W'(bus.a), a_neg));
        b_mag     = WIDTH'(mdu_mag(MDU_MAX_W'(bus.b), b_neg));
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        prod_fix = (2*WIDTH)'(mdu_mag(MDU_MAX_W'(acc), neg_res));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start && op_mul) begin
                    state_next = MUL;
                end
`ifdef MDU_DIV_EN
                else if (bus.start && op_div) begin
                    state_next = (bus.b == '0) ? FIX : DIV;
                end
`endif
            end
            MUL: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
`ifdef MDU_DIV_EN
            DIV: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
`endif
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate, then sign-fix and commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_DIV_EN
            is_div     <= 1'b0;
            neg_rem    <= 1'b0;
            dz         <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (op_mul) begin
                            acc     <= {{WIDTH{1'b0}}, b_mag};
                            opnd    <= a_mag;
                            neg_res <= a_neg ^ b_neg;
                            cnt     <= '0;
                            busy_q  <= 1'b1;
`ifdef MDU_DIV_EN
                            is_div     <= 1'b0;
                            dz         <= 1'b0;
                            div_zero_q <= 1'b0;
`endif
                        end else if (op_div) begin
`ifdef MDU_DIV_EN
                            cnt        <= '0;
                            busy_q     <= 1'b1;
                            div_zero_q <= 1'b0;
                            if (bus.b == '0) begin
                                acc     <= {bus.a, {WIDTH{1'b1}}};
                                neg_res <= 1'b0;
                                neg_rem <= 1'b0;
                                is_div  <= 1'b0;
                                dz      <= 1'b1;
                            end else begin
                                acc     <= {{WIDTH{1'b0}}, a_mag};
                                opnd    <= b_mag;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                                is_div  <= 1'b1;
                                dz      <= 1'b0;
                            end
`else
                            done_q <= 1'b1;
`endif
                        end else if (bus.op == MDU_MTHI) begin
                            hi_q   <= bus.a;
                            done_q <= 1'b1;
`ifdef MDU_DIV_EN
                            div_zero_q <= 1'b0;
`endif
                        end else if (bus.op == MDU_MTLO) begin
                            lo_q   <= bus.a;
                            done_q <= 1'b1;
`ifdef MDU_DIV_EN
                            div_zero_q <= 1'b0;
`endif
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    acc <= {rem_next, quo_next};
                    cnt <= cnt + CNT_W'(1);
                end
`endif
                FIX: begin
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    div_zero_q <= dz;
`else
                    hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
`endif
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
